// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD scan parser: FSM states, digit width,
// blank code and the double-dabble digit correction.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BLANK_CODE  = 4'hF;

    function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= 4'd5) begin
            res = digit + 4'd3;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_scan_parser_if.sv
// Load handshake and committed-result bus between the value source and the parser.
interface bcd_scan_parser_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]    displayValue;
    logic                loadValid;
    logic                loadReady;
    logic                convDone;
    logic                overflow;
    logic [4*DIGITS-1:0] bcdValue;

    modport master (
        output displayValue, loadValid,
        input  loadReady, convDone, overflow, bcdValue
    );

    modport slave (
        input  displayValue, loadValid,
        output loadReady, convDone, overflow, bcdValue
    );
endinterface

// File: rtl/bcd_scan_parser_dabble_core.sv
// Iterative double-dabble converter: IDLE/SHIFT/COMMIT FSM, working registers
// and the committed result register that the display reads.
module bcd_dabble_core
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              value_i,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    output logic                          conv_done_o,
    output logic                          overflow_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_value_o
);
    localparam int BW    = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    work_q, work_d;
    logic [BW-1:0]    adj_s;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    bcd_value_q, bcd_value_d;
    logic             overflow_q, overflow_d;

    // Add-3 correction on every work digit ahead of the shift
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dabble_adjust(work_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        work_d      = work_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        bcd_value_d = bcd_value_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (load_valid_i) begin
                    state_d  = SHIFT;
                    bin_d    = value_i;
                    work_d   = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // A carry out of the top digit means the value needs more digits
                work_d   = {adj_s[BW-2:0], bin_q[WIDTH-1]};
                bin_d    = {bin_q[WIDTH-2:0], 1'b0};
                sticky_d = sticky_q | adj_s[BW-1];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = COMMIT;
                end else begin
                    state_d = SHIFT;
                end
            end
            COMMIT: begin
                bcd_value_d = work_q;
                overflow_d  = sticky_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and working registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            work_q      <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            bcd_value_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            work_q      <= work_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            bcd_value_q <= bcd_value_d;
            overflow_q  <= overflow_d;
        end
    end

    assign load_ready_o = (state_q == IDLE);
    assign conv_done_o  = (state_q == COMMIT);
    assign overflow_o   = overflow_q;
    assign bcd_value_o  = bcd_value_q;

endmodule

// File: rtl/bcd_scan_parser.sv
// Binary-to-BCD parser with a multiplexed seven-segment digit scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the leading nonzero one.
module bcd_scan_parser
    import bcd_pkg::*;
#(
    parameter  int WIDTH       = 16,
    parameter  int DIGITS      = 4,
    parameter  int REFRESH_DIV = 1000,
    localparam int SEL_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    bcd_scan_parser_if.slave  bus,
    output logic [SEL_W-1:0]  digitSelect,
    output logic [DIGITS-1:0] digitEnable,
    output logic [3:0]        displayDigit
);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_s;
    logic                          ovf_s;
    logic [REF_W-1:0]              refresh_q, refresh_d;
    logic [SEL_W-1:0]              index_q, index_d;
    logic [DIGITS-1:0]             blank_s;
    logic [DIGITS-1:0]             en_s;
    logic [3:0]                    nib_s;
    logic                          blank_sel_s;

    bcd_dabble_core #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .value_i      (bus.displayValue),
        .load_valid_i (bus.loadValid),
        .load_ready_o (bus.loadReady),
        .conv_done_o  (bus.convDone),
        .overflow_o   (ovf_s),
        .bcd_value_o  (bcd_s)
    );

    assign bus.bcdValue = bcd_s;
    assign bus.overflow = ovf_s;

    // Free-running refresh divider and scan index
    always_comb begin
        refresh_d = refresh_q;
        index_d   = index_q;
        if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            if (index_q == SEL_W'(DIGITS - 1)) begin
                index_d = '0;
            end else begin
                index_d = index_q + 1'b1;
            end
        end else begin
            refresh_d = refresh_q + 1'b1;
        end
    end

    // Refresh counter and scan index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_q <= '0;
            index_q   <= '0;
        end else begin
            refresh_q <= refresh_d;
            index_q   <= index_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A position blanks while it and everything above it is zero; digit 0 always shows
    always_comb begin
        logic hi_zero;
        blank_s = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero    = hi_zero & (bcd_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'h0);
            blank_s[i] = hi_zero & ~ovf_s;
        end
    end
`else
    assign blank_s = '0;
`endif

    // Scan mux reads only the committed result, so partial conversions never show
    always_comb begin
        nib_s       = 4'h0;
        en_s        = '0;
        blank_sel_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (index_q == SEL_W'(i)) begin
                nib_s       = bcd_s[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                en_s[i]     = 1'b1;
                blank_sel_s = blank_s[i];
            end else begin
                en_s[i] = 1'b0;
            end
        end
    end

    assign digitSelect  = index_q;
    assign digitEnable  = blank_sel_s ? {DIGITS{1'b0}} : en_s;
    assign displayDigit = blank_sel_s ? BLANK_CODE : nib_s;

endmodule
